// File: rtl/scope_overlay.sv
// 640x480 oscilloscope overlay: VGA timing, cursors, two traces, optional grid.
// Define SCOPE_GRID_EN to build the graticule layer.
module scope_overlay (
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic [10:0] cursorX1,
  input  logic [10:0] cursorX2,
  input  logic [10:0] cursorY1,
  input  logic [10:0] cursorY2,
  input  logic        cursorX_EN,
  input  logic        cursorY_EN,
  input  logic        Wave1_EN,
  input  logic        Wave2_EN,
  input  logic [10:0] offset1,
  input  logic [10:0] offset2,
  input  logic [3:0]  shiftDown1,
  input  logic [3:0]  shiftDown2,
  output logic [9:0]  sampleAddr,
  input  logic [11:0] sample1Data,
  input  logic [11:0] sample2Data,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frameStart,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  typedef struct packed {
    logic [10:0] cx1;
    logic [10:0] cx2;
    logic [10:0] cy1;
    logic [10:0] cy2;
    logic        cx_en;
    logic        cy_en;
    logic        w1_en;
    logic        w2_en;
    logic [10:0] off1;
    logic [10:0] off2;
    logic [3:0]  sh1;
    logic [3:0]  sh2;
  } shadow_t;

  shadow_t shd_q, shd_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [9:0] addr_q, addr_d;

  logic       vis0;
  logic       grid0;

  logic       vis1_q, vis1_d;
  logic       cur1_q, cur1_d;
  logic       grid1_q, grid1_d;
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;
  logic       col0_q, col0_d;
  logic [9:0] v1_q, v1_d;

  logic signed [12:0] prev1_q, prev1_d;
  logic signed [12:0] prev2_q, prev2_d;
  logic signed [12:0] t1, t2, p1, p2, v1s;
  logic               w1_hit, w2_hit;

  logic        hs2_q, hs2_d;
  logic        vs2_q, vs2_d;
  logic        blank2_q, blank2_d;
  logic [23:0] rgb_q, rgb_d;

  function automatic logic wave_hit(
    input logic               en,
    input logic signed [12:0] t,
    input logic signed [12:0] p,
    input logic signed [12:0] y
  );
    logic signed [12:0] lo, hi;
    lo = (t < p) ? t : p;
    hi = (t < p) ? p : t;
    return en && (t >= 13'sd0) && (t <= 13'sd479)
        && (y >= lo) && (y <= hi);
  endfunction

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'd799) begin
      h_d = '0;
      v_d = (v_q == 10'd524) ? '0 : v_q + 10'd1;
    end
    // address leads the counter by one flop so data lands with stage 1
    addr_d = (h_d < 10'd640) ? h_d : '0;
    shd_d = shd_q;
    if (h_q == '0 && v_q == 10'd480) begin
      shd_d = '{
        cx1:   cursorX1,
        cx2:   cursorX2,
        cy1:   cursorY1,
        cy2:   cursorY2,
        cx_en: cursorX_EN,
        cy_en: cursorY_EN,
        w1_en: Wave1_EN,
        w2_en: Wave2_EN,
        off1:  offset1,
        off2:  offset2,
        sh1:   shiftDown1,
        sh2:   shiftDown2
      };
    end
  end

  assign vis0 = (h_q < 10'd640) && (v_q < 10'd480);

`ifdef SCOPE_GRID_EN
  logic [5:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (h_q == 10'd799) begin
      if (v_d == '0) row_d = '0;
      else row_d = (row_q == 6'd59) ? '0 : row_q + 6'd1;
    end
  end

  assign grid0 = vis0 && ((h_q[5:0] == '0) || (row_q == '0));

  always_ff @(posedge pixelClock) begin
    if (!resetN) row_q <= '0;
    else         row_q <= row_d;
  end
`else
  assign grid0 = 1'b0;
`endif

  always_comb begin
    vis1_d  = vis0;
    cur1_d  = vis0 && (
                (shd_q.cx_en && ({1'b0, h_q} == shd_q.cx1 ||
                                 {1'b0, h_q} == shd_q.cx2)) ||
                (shd_q.cy_en && ({1'b0, v_q} == shd_q.cy1 ||
                                 {1'b0, v_q} == shd_q.cy2)));
    grid1_d = grid0;
    hs1_d   = !((h_q >= 10'd656) && (h_q <= 10'd751));
    vs1_d   = !((v_q >= 10'd490) && (v_q <= 10'd491));
    col0_d  = (h_q == '0);
    v1_d    = v_q;
  end

  always_comb begin
    t1  = $signed({2'b00, shd_q.off1})
        - $signed({1'b0, sample1Data >> shd_q.sh1});
    t2  = $signed({2'b00, shd_q.off2})
        - $signed({1'b0, sample2Data >> shd_q.sh2});
    p1  = col0_q ? t1 : prev1_q;
    p2  = col0_q ? t2 : prev2_q;
    v1s = $signed({3'b000, v1_q});
    w1_hit = wave_hit(shd_q.w1_en, t1, p1, v1s);
    w2_hit = wave_hit(shd_q.w2_en, t2, p2, v1s);
    prev1_d = t1;
    prev2_d = t2;
    rgb_d = 24'h000000;
    if (vis1_q) begin
      if (cur1_q)       rgb_d = 24'hFFFF00;
      else if (w1_hit)  rgb_d = 24'h00FF00;
      else if (w2_hit)  rgb_d = 24'h00FFFF;
      else if (grid1_q) rgb_d = 24'h404040;
    end
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    blank2_d = !vis1_q;
  end

  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      shd_q    <= '0;
      vis1_q   <= 1'b0;
      cur1_q   <= 1'b0;
      grid1_q  <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      col0_q   <= 1'b0;
      v1_q     <= '0;
      prev1_q  <= '0;
      prev2_q  <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b1;
      rgb_q    <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      shd_q    <= shd_d;
      vis1_q   <= vis1_d;
      cur1_q   <= cur1_d;
      grid1_q  <= grid1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      col0_q   <= col0_d;
      v1_q     <= v1_d;
      prev1_q  <= prev1_d;
      prev2_q  <= prev2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      blank2_q <= blank2_d;
      rgb_q    <= rgb_d;
    end
  end

  assign sampleAddr = addr_q;
  assign hsync      = hs2_q;
  assign vsync      = vs2_q;
  assign blank      = blank2_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign frameStart = resetN && (h_q == '0) && (v_q == '0);

endmodule

// File: doc/scope_overlay.md
SCOPE_OVERLAY -- requirements
Module: scope_overlay

Interface
REQ-001 Clock/reset: one clock; reset is synchronous and active-low.
REQ-002 pixelClock  input  1  25.175 MHz pixel clock; all logic on rising edge.
REQ-003 resetN  input  1  synchronous active-low reset.
REQ-004 cursorX1, cursorX2, cursorY1, cursorY2  input  11 each  cursor positions in pixels, from the controls block.
REQ-005 cursorX_EN, cursorY_EN, Wave1_EN, Wave2_EN  input  1 each  layer enables.
REQ-006 offset1, offset2  input  11 each  trace baseline row; shiftDown1, shiftDown2  input  4 each  right-shift applied to samples.
REQ-007 sampleAddr  output  10  column index to sample buffer; sample1Data, sample2Data  input  12 each  data, valid exactly 1 cycle after sampleAddr.
REQ-008 hsync, vsync  output  1 each  active-low sync; blank  output  1  high outside the 640x480 visible area; frameStart  output  1  one-cycle pulse.
REQ-009 red, green, blue  output  8 each  pixel colour.

Function
REQ-010 Timing: hCount 0..799 (visible 0-639, hsync low for 656-751); vCount 0..524 (visible 0-479, vsync low for 490-491); hCount wraps to 0 and increments vCount; vCount wraps 524->0.
REQ-011 Shadow: all control inputs copied to shadow registers in one cycle when hCount==0 and vCount==480; the frame is drawn only from shadow values; mid-frame input changes take effect on the next frame.
REQ-012 frameStart high for exactly the cycle hCount==0 and vCount==0.
REQ-013 Pipeline stage 0: sampleAddr = hCount[9:0] (registered) when hCount<640, else 0.
REQ-014 Stage 1: traceY = offset - (sample >> shiftDown), computed 13-bit signed; traceY<0 or traceY>479 marks the column off-screen.
REQ-015 Per wave, prevY holds the previous column's traceY; at column 0 prevY = traceY (no line from the previous row).
REQ-016 Wave pixel lit when the wave is enabled, the column is on-screen and min(prevY,traceY) <= vCount <= max(prevY,traceY).
REQ-017 Cursor pixel lit when (cursorX_EN and hCount==cursorX1 or cursorX2) or (cursorY_EN and vCount==cursorY1 or cursorY2).
REQ-018 Colour priority: cursor FFFF00 > wave1 00FF00 > wave2 00FFFF > grid 404040 > 000000.
REQ-019 Stage 2: RGB registered; hsync, vsync and blank delayed 2 cycles to align with RGB; total latency 2 cycles from counter to pins.
REQ-020 blank=1 forces RGB to 000000.
REQ-021 Cursor values >=640 (X) or >=480 (Y) never draw; no wrap-around.

Reset
REQ-022 While resetN==0: hCount=vCount=0, all shadows 0 (all layers disabled), sampleAddr=0, hsync=vsync=1, blank=1, frameStart=0, RGB=0.
REQ-023 After resetN rises, the first frameStart pulse occurs on the first cycle; the shadow registers stay 0 until the first vCount==480 load.
REQ-024 A reset mid-frame abandons the frame immediately; no partial state persists.

Configuration
REQ-025 SCOPE_GRID_EN defined: grid lit where hCount[5:0]==0 or the row counter (0..59, wraps, cleared at vCount==0) is 0, in the visible area only.
REQ-026 SCOPE_GRID_EN undefined: no grid logic or row counter; grid term is constant 0.

Verification
REQ-027 Reset then free-run 2 frames -> hsync period 800 cycles, low for 96; vsync period 420000 cycles, low for 1600; frameStart every 420000 cycles.
REQ-028 cursorX_EN=1, cursorX1=100 -> RGB FFFF00 at column 100 of every visible row, 2 cycles after hCount==100.
REQ-029 Wave1_EN=1, offset1=240, shiftDown1=2, constant sample 400 -> green only at row 140 in every column.
REQ-030 Change cursorY1 from 50 to 60 at vCount==200 -> row 50 drawn for the rest of the frame; row 60 from the next frame.
REQ-031 Cursor, wave1 and wave2 overlap at one pixel -> FFFF00; set offset2=10 with sample 4095 -> wave2 off-screen, nothing drawn.
REQ-032 With SCOPE_GRID_EN, all layers off -> 404040 at columns 0, 64, ..., 576 and rows 0, 60, ..., 420; without it -> all black.
